jstk_spi_transactor: RTL and testbench

- SPI master engine for the PmodJSTK joystick, clocked by the slow SPI clock domain.
- On each start request it runs one 5-byte mode-0 transaction: CS low, setup delay, 5 bytes with inter-byte gaps, CS high.
- It sends the LED command and unpacks the received bytes into 10-bit x, 10-bit y and 3 buttons.
- Its registered y output feeds the paddle-movement stage; done marks a fresh sample.

---
 rtl/jstk_spi_if.sv | 26 ++
 rtl/jstk_spi_transactor.sv | 162 ++++++++++++++++
 tb/tb_jstk_spi_transactor.sv | 255 +++++++++++++++++++++++++
 3 files changed

// File: rtl/jstk_spi_if.sv
// Request/result bundle between the joystick transactor and its user.
// The slave modport is the transactor's view; master is the requester/joystick side.
interface jstk_spi_if;
    logic       i_start;
    logic       i_ld1;
    logic       i_ld2;
    logic       i_miso;
    logic       o_cs;
    logic       o_sck;
    logic       o_mosi;
    logic [9:0] o_x;
    logic [9:0] o_y;
    logic [2:0] o_btn;
    logic       o_busy;
    logic       o_done;

    modport slave (
        input  i_start, i_ld1, i_ld2, i_miso,
        output o_cs, o_sck, o_mosi, o_x, o_y, o_btn, o_busy, o_done
    );

    modport master (
        output i_start, i_ld1, i_ld2, i_miso,
        input  o_cs, o_sck, o_mosi, o_x, o_y, o_btn, o_busy, o_done
    );
endinterface

// File: rtl/jstk_spi_transactor.sv
// PmodJSTK SPI master: one 5-byte mode-0 frame per start request, decoded
// into registered x/y/buttons that only move on the done edge.
module jstk_spi_transactor #(
    parameter int CS_SETUP_CYC = 15,
    parameter int GAP_CYC      = 10,
    parameter int HOLD_CYC     = 2
) (
    input  logic      i_spi_clk,
    input  logic      i_reset,
    jstk_spi_if.slave bus
);
    localparam int MAX_SG  = (CS_SETUP_CYC > GAP_CYC) ? CS_SETUP_CYC : GAP_CYC;
    localparam int CNT_MAX = (MAX_SG > HOLD_CYC) ? MAX_SG : HOLD_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(CS_SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETUP,
        S_SHIFT,
        S_GAP,
        S_HOLD,
        S_FINISH
    } state_t;

    state_t           r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [2:0]       r_bit;
    logic [2:0]       r_byte;
    logic             r_phase;
    logic [7:0]       r_tx;
    logic [7:0]       r_rx;
    logic [9:0]       r_sx;
    logic [9:0]       r_sy;
    logic [2:0]       r_sb;
    logic             r_cs;
    logic             r_sck;
    logic             r_busy;
    logic             r_done;
    logic [9:0]       r_x;
    logic [9:0]       r_y;
    logic [2:0]       r_btn;

    // NOTE: every register, including the shift and staging registers, is
    // cleared by the async reset so an aborted frame leaves nothing behind.
    always_ff @(posedge i_spi_clk or posedge i_reset) begin
        if (i_reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_bit   <= '0;
            r_byte  <= '0;
            r_phase <= 1'b0;
            r_tx    <= '0;
            r_rx    <= '0;
            r_sx    <= '0;
            r_sy    <= '0;
            r_sb    <= '0;
            r_cs    <= 1'b1;
            r_sck   <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
            r_x     <= 10'h200;
            r_y     <= 10'h200;
            r_btn   <= '0;
        end else begin
            // NOTE: non-blocking assignments throughout, so every branch reads
            // the pre-edge value of each register.
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_tx    <= {6'b100000, bus.i_ld2, bus.i_ld1};
                        r_cs    <= 1'b0;
                        r_busy  <= 1'b1;
                        r_cnt   <= '0;
                        r_bit   <= '0;
                        r_byte  <= '0;
                        r_phase <= 1'b0;
                        r_state <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    if (r_cnt == SETUP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_SHIFT: begin
                    if (!r_phase) begin
                        r_sck   <= 1'b1;
                        r_phase <= 1'b1;
                        r_rx    <= {r_rx[6:0], bus.i_miso};
                    end else begin
                        r_sck   <= 1'b0;
                        r_phase <= 1'b0;
                        r_tx    <= {r_tx[6:0], 1'b0};
                        r_bit   <= r_bit + 1'b1;
                        if (r_bit == 3'd7) begin
                            // Keep only the bits that reach the decoded outputs.
                            case (r_byte)
                                3'd0:    r_sx[7:0] <= r_rx;
                                3'd1:    r_sx[9:8] <= r_rx[1:0];
                                3'd2:    r_sy[7:0] <= r_rx;
                                3'd3:    r_sy[9:8] <= r_rx[1:0];
                                default: r_sb      <= r_rx[2:0];
                            endcase
                            r_byte <= r_byte + 1'b1;
                            if (r_byte == 3'd4) begin
                                r_state <= S_HOLD;
                            end else if (GAP_CYC == 0) begin
                                r_state <= S_SHIFT;
                            end else begin
                                r_state <= S_GAP;
                            end
                        end
                    end
                end
                S_GAP: begin
                    if (r_cnt == GAP_LAST) begin
                        r_cnt   <= '0;
                        r_state <= S_SHIFT;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_cnt == HOLD_LAST) begin
                        r_cnt   <= '0;
                        r_cs    <= 1'b1;
                        r_tx    <= '0;
                        r_done  <= 1'b1;
                        r_x     <= r_sx;
                        r_y     <= r_sy;
                        r_btn   <= r_sb;
                        r_state <= S_FINISH;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                S_FINISH: begin
                    r_done  <= 1'b0;
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.o_cs   = r_cs;
    assign bus.o_sck  = r_sck;
    assign bus.o_mosi = r_tx[7];
    assign bus.o_x    = r_x;
    assign bus.o_y    = r_y;
    assign bus.o_btn  = r_btn;
    assign bus.o_busy = r_busy;
    assign bus.o_done = r_done;
endmodule

// File: tb/tb_jstk_spi_transactor.sv
// Scoreboard bench: default-parameter transactor plus a back-to-back corner
// instance, each talking to a behavioural joystick slave.
module tb_jstk_spi_transactor;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int su_c[2]   = '{15, 1};
    int gap_c[2]  = '{10, 0};
    int hold_c[2] = '{2, 1};
    int lat_c[2]  = '{138, 83};

    logic rst_d[2];
    logic start_d[2];
    logic ld1_d[2];
    logic ld2_d[2];
    logic [39:0] slv_data[2];
    logic [39:0] slv_sr[2] = '{40'h0, 40'h0};
    logic [39:0] slv_cap[2];

    jstk_spi_if bus0 ();
    jstk_spi_if bus1 ();

    jstk_spi_transactor dut0 (.i_spi_clk(clk), .i_reset(rst_d[0]), .bus(bus0));
    jstk_spi_transactor #(.CS_SETUP_CYC(1), .GAP_CYC(0), .HOLD_CYC(1))
        dut1 (.i_spi_clk(clk), .i_reset(rst_d[1]), .bus(bus1));

    assign bus0.i_start = start_d[0];
    assign bus0.i_ld1   = ld1_d[0];
    assign bus0.i_ld2   = ld2_d[0];
    assign bus0.i_miso  = slv_sr[0][39];
    assign bus1.i_start = start_d[1];
    assign bus1.i_ld1   = ld1_d[1];
    assign bus1.i_ld2   = ld2_d[1];
    assign bus1.i_miso  = slv_sr[1][39];

    logic       cs_w[2], sck_w[2], mosi_w[2], busy_w[2], done_w[2], rst_w[2];
    logic [9:0] x_w[2], y_w[2];
    logic [2:0] btn_w[2];
    assign cs_w[0] = bus0.o_cs;     assign cs_w[1] = bus1.o_cs;
    assign sck_w[0] = bus0.o_sck;   assign sck_w[1] = bus1.o_sck;
    assign mosi_w[0] = bus0.o_mosi; assign mosi_w[1] = bus1.o_mosi;
    assign busy_w[0] = bus0.o_busy; assign busy_w[1] = bus1.o_busy;
    assign done_w[0] = bus0.o_done; assign done_w[1] = bus1.o_done;
    assign x_w[0] = bus0.o_x;       assign x_w[1] = bus1.o_x;
    assign y_w[0] = bus0.o_y;       assign y_w[1] = bus1.o_y;
    assign btn_w[0] = bus0.o_btn;   assign btn_w[1] = bus1.o_btn;
    assign rst_w[0] = rst_d[0];     assign rst_w[1] = rst_d[1];

    typedef struct {
        int          dut;
        logic [9:0]  x;
        logic [9:0]  y;
        logic [2:0]  btn;
        logic [39:0] mosi;
        int          start_t;
    } exp_t;
    exp_t sb_q[$];

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    logic       cs_p[2]  = '{1'b1, 1'b1};
    logic       sck_p[2] = '{1'b0, 1'b0};
    logic [9:0] px[2]    = '{10'h200, 10'h200};
    logic [9:0] py[2]    = '{10'h200, 10'h200};
    int csfall_t[2], csrise_t[2], lastfall_t[2];
    int nrise[2]    = '{0, 0};
    int done_cnt[2] = '{0, 0};
    int rise_t[2][40];

    task automatic score(input int i);
        exp_t e;
        check("sb_nonempty", (sb_q.size() > 0), 1);
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            check("sb_dut", e.dut, i);
            check("x", x_w[i], e.x);
            check("y", y_w[i], e.y);
            check("btn", btn_w[i], e.btn);
            check("mosi_frame", slv_cap[i], e.mosi);
            check("start_to_done", cyc - e.start_t, lat_c[i]);
            check("cs_low_len", csrise_t[i] - csfall_t[i], lat_c[i] - 1);
            check("busy_at_done", busy_w[i], 1);
            check("mosi_idle", mosi_w[i], 0);
            check("sck_rises", nrise[i], 40);
            if (nrise[i] == 40) begin
                check("cs_to_first_rise", rise_t[i][0] - csfall_t[i], su_c[i] + 1);
                for (int b = 0; b < 5; b++) begin
                    check("byte_span", rise_t[i][8*b+7] - rise_t[i][8*b], 14);
                    if (b < 4) check("byte_gap", rise_t[i][8*b+8] - rise_t[i][8*b+7], gap_c[i] + 2);
                end
                check("hold", csrise_t[i] - lastfall_t[i], hold_c[i]);
            end
        end
    endtask

    // Joystick slave and bus monitor, both evaluated away from the active edge.
    always @(negedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (cs_p[i] && !cs_w[i]) begin
                csfall_t[i] = cyc;
                nrise[i]    = 0;
                slv_sr[i]   = slv_data[i];
                slv_cap[i]  = '0;
            end
            if (!cs_w[i] && sck_w[i] && !sck_p[i]) begin
                if (nrise[i] < 40) rise_t[i][nrise[i]] = cyc;
                nrise[i]++;
                slv_cap[i] = {slv_cap[i][38:0], mosi_w[i]};
            end
            if (!sck_w[i] && sck_p[i]) begin
                lastfall_t[i] = cyc;
                slv_sr[i]     = {slv_sr[i][38:0], 1'b0};
            end
            if (!cs_p[i] && cs_w[i]) csrise_t[i] = cyc;
            if (!rst_w[i] && (x_w[i] !== px[i] || y_w[i] !== py[i]))
                check("xy_change_only_on_done", done_w[i], 1);
            if (done_w[i]) begin
                done_cnt[i]++;
                score(i);
            end
            cs_p[i]  = cs_w[i];
            sck_p[i] = sck_w[i];
            px[i]    = x_w[i];
            py[i]    = y_w[i];
        end
    end

    task automatic launch(input int i, input bit l1, input bit l2, input logic [39:0] d,
                          input logic [9:0] ex, input logic [9:0] ey, input logic [2:0] eb);
        exp_t e;
        ld1_d[i]    = l1;
        ld2_d[i]    = l2;
        slv_data[i] = d;
        e.dut     = i;
        e.x       = ex;
        e.y       = ey;
        e.btn     = eb;
        e.mosi    = {6'b100000, l2, l1, 32'h0};
        e.start_t = cyc;
        sb_q.push_back(e);
        start_d[i] = 1'b1;
    endtask

    // Returns on the negedge that first sees done; ld bits are flipped mid-frame.
    task automatic wait_done(input int i, input int poke_at, input bit hold_chk,
                             input logic [9:0] hx, input logic [9:0] hy);
        int k = 0;
        bit seen = 1'b0;
        while (!seen && k < lat_c[i] + 20) begin
            @(negedge clk);
            k++;
            start_d[i] = (k == poke_at);
            if (k == 3) begin
                ld1_d[i] = ~ld1_d[i];
                ld2_d[i] = ~ld2_d[i];
            end
            if (hold_chk && (k == 60 || k == lat_c[i] - 5)) begin
                check("x_hold", x_w[i], hx);
                check("y_hold", y_w[i], hy);
            end
            if (done_w[i]) seen = 1'b1;
        end
        check("done_seen", seen, 1);
    endtask

    logic [39:0] rd;
    int          n_done;

    initial begin
        rst_d   = '{1'b1, 1'b1};
        start_d = '{1'b0, 1'b0};
        ld1_d   = '{1'b0, 1'b0};
        ld2_d   = '{1'b0, 1'b0};
        slv_data = '{40'h0, 40'h0};
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check("rst_cs", cs_w[i], 1);
            check("rst_sck", sck_w[i], 0);
            check("rst_mosi", mosi_w[i], 0);
            check("rst_busy", busy_w[i], 0);
            check("rst_done", done_w[i], 0);
            check("rst_x", x_w[i], 10'h200);
            check("rst_y", y_w[i], 10'h200);
            check("rst_btn", btn_w[i], 0);
        end
        rst_d = '{1'b0, 1'b0};
        @(negedge clk);

        // Full frame with a start poke while busy.
        launch(0, 1'b1, 1'b0, 40'h34_02_78_01_05, 10'h234, 10'h178, 3'b101);
        wait_done(0, 50, 1'b0, 10'h0, 10'h0);

        // Start during FINISH is dropped; the first IDLE cycle accepts it.
        start_d[0] = 1'b1;
        @(negedge clk);
        check("finish_start_busy", busy_w[0], 0);
        check("finish_start_cs", cs_w[0], 1);
        launch(0, 1'b0, 1'b1, 40'h9A_01_C3_02_06, 10'h19A, 10'h2C3, 3'b110);
        wait_done(0, 0, 1'b1, 10'h234, 10'h178);
        repeat (2) @(negedge clk);

        // Reset during byte 2 aborts the frame.
        launch(0, 1'b1, 1'b1, 40'h11_22_33_44_55, 10'h211, 10'h033, 3'b101);
        @(negedge clk);
        start_d[0] = 1'b0;
        repeat (74) @(negedge clk);
        check("pre_abort_busy", busy_w[0], 1);
        #3 rst_d[0] = 1'b1;
        #1;
        check("abort_cs", cs_w[0], 1);
        check("abort_sck", sck_w[0], 0);
        check("abort_busy", busy_w[0], 0);
        check("abort_done", done_w[0], 0);
        check("abort_x", x_w[0], 10'h200);
        check("abort_y", y_w[0], 10'h200);
        check("abort_btn", btn_w[0], 0);
        void'(sb_q.pop_back());
        n_done = done_cnt[0];
        repeat (3) @(negedge clk);
        rst_d[0] = 1'b0;
        repeat (150) @(negedge clk);
        check("no_done_after_abort", done_cnt[0], n_done);

        // Clean frame after reset with random slave data.
        rd[31:0]  = $urandom();
        rd[39:32] = 8'($urandom());
        launch(0, 1'($urandom()), 1'($urandom()), rd,
               {rd[25:24], rd[39:32]}, {rd[9:8], rd[23:16]}, rd[2:0]);
        wait_done(0, 0, 1'b1, 10'h200, 10'h200);
        repeat (2) @(negedge clk);

        // Back-to-back corner instance.
        launch(1, 1'b0, 1'b1, 40'hFF_03_00_00_07, 10'h3FF, 10'h000, 3'b111);
        wait_done(1, 0, 1'b1, 10'h200, 10'h200);
        repeat (5) @(negedge clk);

        check("sb_drained", sb_q.size(), 0);
        check("done_count_dut0", done_cnt[0], 3);
        check("done_count_dut1", done_cnt[1], 1);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
